// File: rtl/probe_pattern_gen_if.sv
// Control and probe bundle between the pattern generator and whatever drives it.
// The generator takes the slave side; the stimulus host (or a bench) takes the master side.
interface probe_pattern_gen_if;
  logic [1:0]  mode;
  logic        start;
  logic        stop;
  logic        probe0;
  logic [3:0]  probe1;
  logic [7:0]  probe2;
  logic [15:0] probe3;
  logic        active;
  logic        done;

  modport master (
    output mode, start, stop,
    input  probe0, probe1, probe2, probe3, active, done
  );

  modport slave (
    input  mode, start, stop,
    output probe0, probe1, probe2, probe3, active, done
  );
endinterface

// File: rtl/probe_pattern_gen.sv
// Deterministic probe stimulus: counter, LFSR, walking-one and Gray patterns, optionally bursted.
// Build option: define PROBE_PATTERN_GEN_LFSR_EN to include LFSR mode; otherwise mode 1 acts as counter.
module probe_pattern_gen #(
  parameter int          BURST_LEN = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  probe_pattern_gen_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = (BURST_LEN == 0) ? 1 : $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

`ifdef PROBE_PATTERN_GEN_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  if (LFSR_EN && (LFSR_SEED == 16'h0000)) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  pat, pat_nxt;
  logic [DATA_W-1:0]  b, b_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         lmode, lmode_nxt;

  // Without the LFSR build, mode 1 collapses onto the counter.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef PROBE_PATTERN_GEN_LFSR_EN
    return m;
`else
    return (m == 2'd1) ? 2'd0 : m;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] init_pat(input logic [1:0] m);
    case (eff_mode(m))
`ifdef PROBE_PATTERN_GEN_LFSR_EN
      2'd1:    return LFSR_SEED;
`endif
      2'd2:    return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // bn is the already-incremented hidden binary count used by Gray mode.
  function automatic logic [DATA_W-1:0] next_pat(input logic [1:0]        m,
                                                 input logic [DATA_W-1:0] p,
                                                 input logic [DATA_W-1:0] bn);
    case (eff_mode(m))
`ifdef PROBE_PATTERN_GEN_LFSR_EN
      2'd1:    return p[0] ? ((p >> 1) ^ 16'hB400) : (p >> 1);
`endif
      2'd2:    return {p[DATA_W-2:0], p[DATA_W-1]};
      2'd3:    return bn ^ (bn >> 1);
      default: return p + 16'd1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat   <= '0;
      b     <= '0;
      cnt   <= '0;
      lmode <= '0;
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      b     <= b_nxt;
      cnt   <= cnt_nxt;
      lmode <= lmode_nxt;
    end
  end

  // Stop wins over start; a start in any state (re)loads the run.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    b_nxt     = b;
    cnt_nxt   = cnt;
    lmode_nxt = lmode;
    if (bus.stop) begin
      state_nxt = IDLE;
    end else if (bus.start) begin
      state_nxt = RUN;
      lmode_nxt = bus.mode;
      pat_nxt   = init_pat(bus.mode);
      b_nxt     = '0;
      cnt_nxt   = CNT_W'(1);
    end else if (state == RUN) begin
      if ((BURST_LEN != 0) && (cnt == BURST_CNT)) begin
        state_nxt = DONE;
      end else begin
        b_nxt   = b + 16'd1;
        pat_nxt = next_pat(lmode, pat, b + 16'd1);
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign bus.probe3 = pat;
  assign bus.probe2 = pat[7:0];
  assign bus.probe1 = pat[3:0];
  assign bus.probe0 = pat[0];
  assign bus.active = (state == RUN);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_probe_pattern_gen.sv
// Bench for probe_pattern_gen: a bursted (len 5) and a free-running instance driven in lockstep,
// compared every cycle against an index-based reference of the pattern sequences.
module tb_probe_pattern_gen;

  localparam int L_B = 5;
  localparam int L_F = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  probe_pattern_gen_if bus_b ();
  probe_pattern_gen_if bus_f ();

  probe_pattern_gen #(.BURST_LEN(L_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  probe_pattern_gen #(.BURST_LEN(L_F)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f));

  int errors = 0;
  int checks = 0;

  bit          m_act  [2];
  bit          m_done [2];
  int          m_idx  [2];
  logic [1:0]  m_mode [2];
  logic [15:0] m_val  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // k-th value (0-based) presented by a run in mode m.
  function automatic logic [15:0] pat_at(input logic [1:0] m, input int k);
    logic [15:0] v;
`ifndef PROBE_PATTERN_GEN_LFSR_EN
    if (m == 2'd1) m = 2'd0;
`endif
    case (m)
      2'd0: return 16'(k);
      2'd1: begin
        v = 16'hACE1;
        for (int j = 0; j < k; j++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
      end
      2'd2: return 16'h0001 << (k % 16);
      default: return 16'(k) ^ (16'(k) >> 1);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_idx[i] = 0; m_mode[i] = 2'd0; m_val[i] = 16'h0;
    end
  endtask

  task automatic model_step(input int i, input int len, input logic st, input logic sp,
                            input logic [1:0] md);
    if (sp) begin
      m_act[i] = 0; m_done[i] = 0;
    end else if (st) begin
      m_act[i] = 1; m_done[i] = 0; m_idx[i] = 0; m_mode[i] = md; m_val[i] = pat_at(md, 0);
    end else if (m_act[i]) begin
      if (len != 0 && m_idx[i] + 1 == len) begin
        m_act[i] = 0; m_done[i] = 1;
      end else begin
        m_idx[i]++;
        m_val[i] = pat_at(m_mode[i], m_idx[i]);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".b.p3"},  bus_b.probe3, m_val[0]);
    chk({tag, ".b.p2"},  bus_b.probe2, m_val[0][7:0]);
    chk({tag, ".b.p1"},  bus_b.probe1, m_val[0][3:0]);
    chk({tag, ".b.p0"},  bus_b.probe0, m_val[0][0]);
    chk({tag, ".b.act"}, bus_b.active, m_act[0]);
    chk({tag, ".b.dn"},  bus_b.done,   m_done[0]);
    chk({tag, ".f.p3"},  bus_f.probe3, m_val[1]);
    chk({tag, ".f.p2"},  bus_f.probe2, m_val[1][7:0]);
    chk({tag, ".f.p1"},  bus_f.probe1, m_val[1][3:0]);
    chk({tag, ".f.p0"},  bus_f.probe0, m_val[1][0]);
    chk({tag, ".f.act"}, bus_f.active, m_act[1]);
    chk({tag, ".f.dn"},  bus_f.done,   m_done[1]);
  endtask

  task automatic step(input logic st, input logic sp, input logic [1:0] md, input string tag);
    bus_b.start = st; bus_b.stop = sp; bus_b.mode = md;
    bus_f.start = st; bus_f.stop = sp; bus_f.mode = md;
    @(posedge clk);
    #1;
    model_step(0, L_B, st, sp, md);
    model_step(1, L_F, st, sp, md);
    compare_all(tag);
    bus_b.start = 1'b0; bus_b.stop = 1'b0;
    bus_f.start = 1'b0; bus_f.stop = 1'b0;
  endtask

  logic [15:0] gexp [6] = '{16'd0, 16'd1, 16'd3, 16'd2, 16'd6, 16'd6};
  logic [15:0] lexp [3];

  initial begin
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.mode = 2'd0;
    bus_f.start = 1'b0; bus_f.stop = 1'b0; bus_f.mode = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;
    step(0, 0, 2'd0, "idle");

    // Counter burst on the length-5 instance, then hold.
    step(1, 0, 2'd0, "cnt");
    for (int k = 1; k <= 6; k++) step(0, 0, 2'd3, "cnt");
    chk("cnt_hold_p3", bus_b.probe3, 16'd4);
    chk("cnt_hold_done", bus_b.done, 1'b1);

    // Gray burst.
    step(1, 0, 2'd3, "gray");
    chk("gray_v0", bus_b.probe3, gexp[0]);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 2'd0, "gray");
      chk("gray_v", bus_b.probe3, gexp[k]);
    end
    chk("gray_done", bus_b.done, 1'b1);

    // Walking-one free run, 17 values, wraps back to 0x0001.
    step(1, 0, 2'd2, "walk");
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 2'd1, "walk");
      if (k == 8) chk("walk_p2_zero", bus_f.probe2, 8'h00);
    end
    chk("walk_wrap", bus_f.probe3, 16'h0001);
    chk("walk_no_done", bus_f.done, 1'b0);

    // Mode 1: LFSR or counter depending on build.
`ifdef PROBE_PATTERN_GEN_LFSR_EN
    lexp = '{16'hACE1, 16'hE270, 16'h7138};
`else
    lexp = '{16'h0000, 16'h0001, 16'h0002};
`endif
    step(1, 0, 2'd1, "lfsr");
    chk("lfsr_v0", bus_b.probe3, lexp[0]);
    step(0, 0, 2'd0, "lfsr");
    chk("lfsr_v1", bus_b.probe3, lexp[1]);
    step(0, 0, 2'd0, "lfsr");
    chk("lfsr_v2", bus_b.probe3, lexp[2]);

    // Stop and start together at value 7 on the free-running instance.
    step(1, 0, 2'd0, "ss");
    for (int k = 1; k <= 7; k++) step(0, 0, 2'd0, "ss");
    step(1, 1, 2'd0, "ss_both");
    chk("ss_hold", bus_f.probe3, 16'd7);
    chk("ss_inactive", bus_f.active, 1'b0);
    step(1, 0, 2'd0, "ss_restart");
    chk("ss_restart_v", bus_f.probe3, 16'd0);
    step(0, 0, 2'd0, "ss");
    step(0, 0, 2'd0, "ss");
    step(1, 0, 2'd0, "run_restart");
    chk("run_restart_v", bus_b.probe3, 16'd0);
    for (int k = 1; k <= 6; k++) step(0, 0, 2'd0, "run_restart");
    chk("run_restart_done", bus_b.done, 1'b1);

    // Asynchronous reset in the middle of a run.
    step(1, 0, 2'd3, "ar");
    for (int k = 1; k <= 3; k++) step(0, 0, 2'd0, "ar");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("areset_now");
    @(posedge clk);
    #1;
    compare_all("areset_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(0, 0, 2'd0, "post_reset");

    // Randomized traffic, mode wiggling throughout.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
           2'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/probe_pattern_gen.md
# probe_pattern_gen

Deterministic stimulus source that drives the four logic-analyzer probe inputs (1, 4, 8 and 16 bits) of the Manta core on the Nexys A7 Ethernet build. It replaces free-running probe counters with selectable patterns: counter, LFSR, walking-one and Gray. Patterns can run as a bounded burst, so host-side captures can be checked against known sequences. It sits directly upstream of the Manta probe ports, in the Ethernet reference-clock domain.

## Interface
Parameters:
- BURST_LEN, default 64: values presented per run; 0 means free-run until stop.
- LFSR_SEED, default 16'hACE1: LFSR load value; must be nonzero.

Ports:
- clk  in  1  one clock; probe clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- mode  in  2  pattern select (0 counter, 1 LFSR, 2 walking-one, 3 Gray); sampled only when start is accepted.
- start  in  1  single-cycle pulse; begins or restarts a run.
- stop  in  1  single-cycle pulse; aborts a run.
- probe0  out  1  bit 0 of the 16-bit pattern word.
- probe1  out  4  bits 3:0 of the pattern word.
- probe2  out  8  bits 7:0 of the pattern word.
- probe3  out  16  the full pattern word.
- active  out  1  high while in RUN.
- done  out  1  high in DONE (burst completed).

## Operation
- Internal state: 16-bit pattern register `pat`, latched mode `lmode`, and burst counter `cnt`.
  - `cnt` width is $clog2(BURST_LEN+1), minimum 1.
  - probe3 = `pat`, probe2 = `pat[7:0]`, probe1 = `pat[3:0]`, probe0 = `pat[0]`. All are registered.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start (stop low): latch mode, load the initial pattern, set cnt=1, go to RUN.
  - RUN + start (stop low): restart. Reload the initial pattern, cnt=1, stay in RUN, relatch mode.
  - RUN, no start/stop: advance the pattern and increment cnt.
  - RUN with BURST_LEN≠0 and cnt==BURST_LEN: on that cycle, do not advance; go to DONE.
  - Any state + stop: go to IDLE, pattern holds. Stop beats start when both occur together.
- Initial patterns and advance rules per mode:
  - Counter: initial 0x0000; `pat+1`, wrapping mod 2^16.
  - LFSR: initial LFSR_SEED; Galois right shift, if old lsb=1 then `(pat>>1)^16'hB400`, else `pat>>1`.
  - Walking-one: initial 0x0001; rotate left by 1, so 0x8000 becomes 0x0001.
  - Gray: a hidden 16-bit binary counter `b` starts at 0 and increments; `pat = b ^ (b>>1)`.
- Pattern holds in IDLE and DONE.
- Reset: `pat`=0, `b`=0, `cnt`=0, `lmode`=0, state IDLE. All probes 0, active=0, done=0.
- Reset mid-run aborts immediately, asynchronously. No run resumes after reset is released.

## Timing
- start sampled high at edge N: at N+1, active=1 and probes show the initial pattern.
- Each later edge in RUN presents the next value.
- Burst (BURST_LEN=L): values 1..L appear on edges N+1..N+L. At N+L+1, active=0, done=1, and probes still hold value L.
- stop sampled at edge M: at M+1, active=0, done=0, probes hold the value from M.
- done clears on the edge that accepts start or stop.
- mode changes during RUN have no effect until the next accepted start.
- Latency from start to first value is 1 cycle; no other pipelining.

## Configuration
- PROBE_PATTERN_GEN_LFSR_EN:
  - Defined: LFSR mode is implemented as specified.
  - Undefined: LFSR logic is omitted, and mode 1 behaves exactly as mode 0 (counter). LFSR_SEED is ignored.

## Test plan
- Counter, BURST_LEN=4, start: probe3 = 0,1,2,3 on four consecutive cycles. Then done=1, active=0, probe3 holds 3, probe1=3, probe0=1.
- LFSR (macro defined), BURST_LEN=3, seed 0xACE1: probe3 = 0xACE1, 0xE270, 0x7138, then done. Same stimulus without the macro: 0,1,2.
- Walking-one, BURST_LEN=0, run 17 cycles: 0x0001, 0x0002, …, 0x8000, 0x0001. probe2 is 0x00 from the value 0x0100 through 0x8000. done never asserts.
- Gray, BURST_LEN=5: probe3 = 0,1,3,2,6, then hold 6 with done=1.
- Counter free-run, stop and start in the same cycle at value 7: next cycle active=0 and probe3=7. A later lone start restarts at 0. A start during RUN restarts at 0 with cnt reset.
- rst_n low mid-run, asynchronous to clk: probes, active and done go 0 immediately. After release, the block stays IDLE until start.
